bram_dp_v3: RTL

//  Single-clock simple-dual-port block RAM: port A read/write with byte enables, port B read-only.

---
 rtl/bram_dp_v3_pkg.sv | 40 ++++
 rtl/bram_dp_v3_if.sv | 33 +++
 rtl/bram_dp_v3_init_fsm.sv | 59 +++++
 rtl/bram_dp_v3.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bram_dp_v3_pkg.sv
// rtl/bram_dp_v3_pkg.sv - shared types, defaults and byte-merge helper for bram_dp_v3
package bram_dp_v3_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_ADDR_WIDTH     = 9;
  localparam int DEF_BYTE_WIDTH     = 8;
  localparam int DEF_WRITE_MODE     = 0;
  localparam int DEF_OUT_REG        = 1;
  localparam int DEF_CLEAR_ON_RESET = 1;

  // Upper bounds for the width-generic merge helper
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_NB         = 64;

  typedef enum logic [1:0] {
    WM_READ_FIRST  = 2'd0,
    WM_WRITE_FIRST = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } bram_wmode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } init_state_e;

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_NB-1:0]         be,
    input int                        byte_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (be[i / byte_width]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_dp_v3_if.sv
// rtl/bram_dp_v3_if.sv - port A read/write and port B read bundle for bram_dp_v3
interface bram_dp_v3_if
  import bram_dp_v3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  ena;
  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  douta_vld;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  doutb_vld;
  logic                  init_busy;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  douta, douta_vld, doutb, doutb_vld, init_busy
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output douta, douta_vld, doutb, doutb_vld, init_busy
  );

endinterface

// File: rtl/bram_dp_v3_init_fsm.sv
// rtl/bram_dp_v3_init_fsm.sv - post-reset clear engine walking every RAM word once
module bram_dp_v3_init_fsm
  import bram_dp_v3_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  // One extra counter bit keeps the terminal compare from aliasing on wrap
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
  localparam init_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_we    = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        init_busy = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign clr_addr = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/bram_dp_v3.sv
// rtl/bram_dp_v3.sv - simple dual-port BRAM: byte-enabled port A, read-only port B, clear engine
module bram_dp_v3
  import bram_dp_v3_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BYTE_WIDTH     = DEF_BYTE_WIDTH,
  parameter int WRITE_MODE     = DEF_WRITE_MODE,
  parameter int OUT_REG        = DEF_OUT_REG,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input logic         clka,
  input logic         rsta_n,
  bram_dp_v3_if.slave bus
);

  localparam int NB        = DATA_WIDTH / BYTE_WIDTH;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam bram_wmode_e WMODE = bram_wmode_e'(2'(WRITE_MODE));

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
    $error("bram_dp_v3: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_write_mode
    $error("bram_dp_v3: WRITE_MODE must be 0, 1 or 2");
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("bram_dp_v3: DATA_WIDTH exceeds merge helper width");
  end

  logic                  init_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  bram_dp_v3_init_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_fsm (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic                  a_en_q, b_en_q;
  logic [NB-1:0]         a_we_q;
  logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
  logic [DATA_WIDTH-1:0] a_din_q;

  // Requests arriving while the clear engine runs are dropped at capture
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      a_en_q   <= 1'b0;
      a_we_q   <= '0;
      a_addr_q <= '0;
      a_din_q  <= '0;
      b_en_q   <= 1'b0;
      b_addr_q <= '0;
    end else begin
      a_en_q   <= bus.ena & ~init_busy;
      a_we_q   <= bus.wea;
      a_addr_q <= bus.addra;
      a_din_q  <= bus.dina;
      b_en_q   <= bus.enb & ~init_busy;
      b_addr_q <= bus.addrb;
    end
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_a, rd_b, a_merged;
  logic                  a_wr, collide;

  assign rd_a     = mem[a_addr_q];
  assign rd_b     = mem[b_addr_q];
  assign a_wr     = a_en_q & (|a_we_q);
  assign collide  = a_wr & (a_addr_q == b_addr_q);
  assign a_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(rd_a), MAX_DATA_WIDTH'(a_din_q),
                                           MAX_NB'(a_we_q), BYTE_WIDTH));

  always_ff @(posedge clka) begin
    if (rsta_n) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (a_wr) begin
        mem[a_addr_q] <= a_merged;
      end
    end
  end

  logic [DATA_WIDTH-1:0] a_dout_s2, b_dout_s2;
  logic                  a_vld_s2, b_vld_s2;

  // Read-before-write array semantics give READ_FIRST for free; the bypass covers WRITE_FIRST
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      a_dout_s2 <= '0;
      a_vld_s2  <= 1'b0;
      b_dout_s2 <= '0;
      b_vld_s2  <= 1'b0;
    end else begin
      a_vld_s2 <= 1'b0;
      b_vld_s2 <= 1'b0;
      if (a_en_q) begin
        if (a_wr) begin
          case (WMODE)
            WM_READ_FIRST: begin
              a_dout_s2 <= rd_a;
              a_vld_s2  <= 1'b1;
            end
            WM_WRITE_FIRST: begin
              a_dout_s2 <= a_merged;
              a_vld_s2  <= 1'b1;
            end
            default: begin
              a_vld_s2 <= 1'b0;
            end
          endcase
        end else begin
          a_dout_s2 <= rd_a;
          a_vld_s2  <= 1'b1;
        end
      end
      if (b_en_q) begin
        b_dout_s2 <= (collide && WMODE == WM_WRITE_FIRST) ? a_merged : rd_b;
        b_vld_s2  <= 1'b1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] douta_r, doutb_r;
  logic                  douta_vld_r, doutb_vld_r;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clka) begin
      if (!rsta_n) begin
        douta_r     <= '0;
        douta_vld_r <= 1'b0;
        doutb_r     <= '0;
        doutb_vld_r <= 1'b0;
      end else begin
        douta_vld_r <= a_vld_s2;
        doutb_vld_r <= b_vld_s2;
        if (a_vld_s2) douta_r <= a_dout_s2;
        if (b_vld_s2) doutb_r <= b_dout_s2;
      end
    end
  end else begin : g_no_out_reg
    assign douta_r     = a_dout_s2;
    assign douta_vld_r = a_vld_s2;
    assign doutb_r     = b_dout_s2;
    assign doutb_vld_r = b_vld_s2;
  end

  assign bus.douta     = douta_r;
  assign bus.douta_vld = douta_vld_r;
  assign bus.doutb     = doutb_r;
  assign bus.doutb_vld = doutb_vld_r;
  assign bus.init_busy = init_busy;

endmodule
